memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Sequential arbiter sharing the single unified RAM port between the instruction-fetch requester (iREN/iaddr) and the data requester (dREN/dWEN/daddr/dstore).
- Sits between the pipeline datapath and RAM, and returns per-requester wait/load signals.
- Data has priority, with a starvation guard for fetch.
- A per-transaction timeout and RAM error response set a sticky error flag.

Parameters:
MAX_D_STREAK, 4, max consecutive data grants completed while iREN pending before fetch is forced
TIMEOUT, 64, max cycles a granted transaction may wait for ramstate==ACCESS

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
iREN  input  1  instruction read request, held until iwait low
iaddr  input  32  instruction address
dREN  input  1  data read request, held until dwait low
dWEN  input  1  data write request, held until dwait low
daddr  input  32  data address
dstore  input  32  data write value
iwait  output  1  instruction request not yet serviced
dwait  output  1  data request not yet serviced
iload  output  32  instruction read data, valid when iREN & ~iwait
dload  output  32  data read data, valid when dREN & ~dwait
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  0=FREE, 1=BUSY, 2=ACCESS, 3=ERROR
mem_err  output  1  sticky: timeout or RAM ERROR seen

Behaviour:
- Reset is asynchronous and active-low. On reset: state IDLE, streak=0, tcount=0, mem_err=0.
- FSM states are IDLE, IGNT and DGNT. State is registered; all other outputs are combinational from state and inputs.
- dreq = dREN|dWEN.
- IDLE
  - ram* outputs are 0.
  - If dreq & ~(iREN & streak==MAX_D_STREAK): next state DGNT.
  - Else if iREN: next state IGNT.
  - Else: stay in IDLE.
  - tcount cleared.
- DGNT
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN. ramREN=dREN&~dWEN, so write wins when both are asserted.
- IGNT
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion in a grant state occurs when any of these holds:
  - ramstate==ACCESS;
  - ramstate==ERROR;
  - tcount==TIMEOUT-1.
- On completion:
  - The owning wait is low for that cycle.
  - The load output is ramload on ACCESS and 32'hBAD1BAD1 on error or timeout.
  - Next state is IDLE.
  - ERROR or timeout sets mem_err=1, which holds until reset.
- Otherwise tcount increments, saturating at TIMEOUT-1.
- Abort: if the owning request drops while in a grant state, return to IDLE next cycle. No completion occurs, mem_err is unchanged, and streak is unchanged.
- iwait = iREN & ~(state==IGNT & completion).
- dwait = dreq & ~(state==DGNT & completion).
- iload and dload are 0 when not completing.
- Latency: request is seen in IDLE at cycle 0, RAM is driven from cycle 1, and the earliest completion is cycle 1. Back-to-back transactions are separated by one IDLE cycle.
- Streak counter, width $clog2(MAX_D_STREAK+1):
  - On data completion with iREN high: +1, saturating at MAX_D_STREAK.
  - On data completion with iREN low: cleared.
  - On instruction completion: cleared.
- Simultaneous iREN and dreq in IDLE with streak<MAX: data is granted.
- Simultaneous iREN and dreq in IDLE with streak==MAX: instruction is granted.
- Requester inputs (addr/store) are sampled combinationally each grant cycle. Requesters hold them stable until wait is low.
- Reset mid-transaction: all ram enables drop immediately (asynchronous), and the FSM returns to IDLE.

Test Plan:
1. Fetch only, iREN=1 iaddr=0x40, RAM returns ACCESS on 2nd grant cycle with ramload=0x3C010001 -> ramREN=1 ramaddr=0x40 in cycles 1-2, iwait=0 and iload=0x3C010001 in cycle 2, back to IDLE cycle 3.
2. Simultaneous iREN and dWEN daddr=0x80 dstore=0xDEADBEEF, RAM ACCESS immediately -> DGNT first (ramWEN=1, ramaddr=0x80), dwait=0 in cycle 1, then IGNT in cycle 3, iwait=0 in cycle 3.
3. Starvation: iREN held, dREN held for 6 transactions, ACCESS immediate -> exactly 4 data completions, then 1 instruction completion, then data resumes; streak returns to 0 after the fetch.
4. Timeout: dREN=1, ramstate held BUSY -> completion at grant cycle 64, dwait=0, dload=0xBAD1BAD1, mem_err=1 and stays 1 through later good transactions.
5. RAM ERROR on fetch -> iwait=0 that cycle, iload=0xBAD1BAD1, mem_err=1; dREN and dWEN both high next -> ramWEN=1 ramREN=0.
6. nRST low during DGNT with ramWEN=1 -> ramWEN=0 asynchronously, mem_err=0; abort (dREN drops in DGNT) -> IDLE next cycle, no dwait-low pulse, streak unchanged.

Source files
------------

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : memory_arbiter
//  Purpose  : Shares one unified RAM port between instruction fetch and data
//             accesses. Data has priority, with a streak limit that forces a
//             pending fetch through. A per-transaction timeout and RAM ERROR
//             responses set a sticky error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        iwait,
   output logic        dwait,
   output logic [31:0] iload,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        mem_err
);

   localparam int          SW        = $clog2(MAX_D_STREAK + 1);
   localparam int          TW        = $clog2(TIMEOUT);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
   localparam logic [TW-1:0] TCOUNT_MAX = TW'(TIMEOUT - 1);
   localparam logic [1:0]  RS_ACCESS = 2'd2;
   localparam logic [1:0]  RS_ERROR  = 2'd3;
   localparam logic [31:0] ERR_WORD  = 32'hBAD1BAD1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [SW-1:0] streak;
   logic [TW-1:0] tcount;

   logic dreq;
   logic ends;       // grant-cycle termination condition (ACCESS, ERROR or timeout)
   logic bad_end;    // termination that did not deliver good data
   logic complete;   // owning request still present and transaction finished

   assign dreq    = dREN | dWEN;
   assign ends    = (ramstate == RS_ACCESS) || (ramstate == RS_ERROR) || (tcount == TCOUNT_MAX);
   assign bad_end = ends && (ramstate != RS_ACCESS);

   // Next-state selection, RAM drive and requester handshake outputs
   always_comb begin
      next_state = state;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = 32'h0;
      ramstore   = 32'h0;
      iwait      = iREN;
      dwait      = dreq;
      iload      = 32'h0;
      dload      = 32'h0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            // Data wins unless a pending fetch has already waited out a full streak
            if (dreq && !(iREN && (streak == STREAK_MAX))) begin
               next_state = DGNT;
            end else if (iREN) begin
               next_state = IGNT;
            end
         end
         DGNT: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (!dreq) begin
               next_state = IDLE;                 // requester withdrew: abort quietly
            end else if (ends) begin
               complete   = 1'b1;
               dwait      = 1'b0;
               dload      = bad_end ? ERR_WORD : ramload;
               next_state = IDLE;
            end
         end
         IGNT: begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            if (!iREN) begin
               next_state = IDLE;
            end else if (ends) begin
               complete   = 1'b1;
               iwait      = 1'b0;
               iload      = bad_end ? ERR_WORD : ramload;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   // Grant-cycle counter: restarts with every transaction, saturates at the timeout point
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         tcount <= '0;
      end else if ((state == IDLE) || (next_state == IDLE)) begin
         tcount <= '0;
      end else if (tcount != TCOUNT_MAX) begin
         tcount <= tcount + 1'b1;
      end
   end

   // Sticky error flag: set by any ERROR or timeout completion
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                  mem_err <= 1'b0;
      else if (complete && bad_end) mem_err <= 1'b1;
   end

   // Count data completions that happened while a fetch was kept waiting
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         streak <= '0;
      end else if (complete) begin
         if ((state == DGNT) && iREN) begin
            if (streak != STREAK_MAX) streak <= streak + 1'b1;
         end else begin
            streak <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_arbiter
//  Purpose  : Directed and randomized self-checking bench for memory_arbiter
//             against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

   localparam int          MAX_D_STREAK = 4;
   localparam int          TIMEOUT      = 64;
   localparam logic [1:0]  RS_FREE   = 2'd0;
   localparam logic [1:0]  RS_BUSY   = 2'd1;
   localparam logic [1:0]  RS_ACCESS = 2'd2;
   localparam logic [1:0]  RS_ERROR  = 2'd3;
   localparam logic [31:0] BAD       = 32'hBAD1BAD1;
   localparam int          OC_ACCESS = 0;
   localparam int          OC_ERROR  = 1;
   localparam int          OC_TOUT   = 2;

   logic        CLK, nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore;
   logic        iwait, dwait;
   logic [31:0] iload, dload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;
   logic        mem_err;

   int checks = 0;
   int errors = 0;
   int m_streak = 0;    // model: data completions while fetch waited
   bit m_err = 0;       // model: sticky error
   bit obs_d;           // which requester the DUT drove onto RAM in grant cycle 1
   bit gd;
   bit pat [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   memory_arbiter #(.MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic next_idle();
      tick();
      ramstate = RS_FREE;
      ramload  = 32'h0;
   endtask

   // Runs one arbitrated transaction starting from the current IDLE cycle.
   // lat = grant cycle on which RAM answers; outcome selects ACCESS/ERROR/never.
   task automatic serve(input int lat, input int outcome, input logic [31:0] load, output bit g_d);
      bit          done;
      logic [31:0] e_load;
      g_d = (dREN | dWEN) && !(iREN && (m_streak == MAX_D_STREAK));
      chk("idle_ramren", ramREN, 0);
      chk("idle_ramwen", ramWEN, 0);
      chk("idle_iwait", iwait, iREN);
      chk("idle_dwait", dwait, dREN | dWEN);
      chk("mem_err", mem_err, m_err);
      done = 0;
      for (int k = 1; k <= TIMEOUT && !done; k++) begin
         tick();
         if (outcome != OC_TOUT && k == lat) ramstate = (outcome == OC_ACCESS) ? RS_ACCESS : RS_ERROR;
         else                                 ramstate = RS_BUSY;
         ramload = (k == lat) ? load : $urandom;
         #1;
         done   = (outcome != OC_TOUT && k == lat) || (k == TIMEOUT);
         e_load = !done ? 32'h0 : ((outcome == OC_ACCESS) ? load : BAD);
         if (k == 1) obs_d = (ramaddr === daddr) && (ramaddr !== iaddr);
         if (g_d) begin
            chk("d_ramwen", ramWEN, dWEN);
            chk("d_ramren", ramREN, dREN & ~dWEN);
            chk("d_ramaddr", ramaddr, daddr);
            chk("d_ramstore", ramstore, dstore);
            chk("d_dwait", dwait, !done);
            chk("d_dload", dload, e_load);
            chk("d_iwait", iwait, iREN);
            chk("d_iload", iload, 0);
         end else begin
            chk("i_ramren", ramREN, 1);
            chk("i_ramwen", ramWEN, 0);
            chk("i_ramaddr", ramaddr, iaddr);
            chk("i_ramstore", ramstore, 0);
            chk("i_iwait", iwait, !done);
            chk("i_iload", iload, e_load);
            chk("i_dwait", dwait, dREN | dWEN);
            chk("i_dload", dload, 0);
         end
      end
      if (outcome != OC_ACCESS) m_err = 1;
      if (g_d && iREN) m_streak = (m_streak < MAX_D_STREAK) ? m_streak + 1 : MAX_D_STREAK;
      else             m_streak = 0;
   endtask

   initial begin
      nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = RS_FREE;

      // Reset state
      #23;
      chk("rst_ramren", ramREN, 0);
      chk("rst_ramwen", ramWEN, 0);
      chk("rst_mem_err", mem_err, 0);
      chk("rst_iwait", iwait, 0);
      nRST = 1'b1;
      next_idle();

      // Fetch only, answered on 2nd grant cycle
      iREN = 1; iaddr = 32'h40;
      #1;
      serve(2, OC_ACCESS, 32'h3C010001, gd);
      next_idle();
      iREN = 0;
      #1;
      chk("t1_idle_ramren", ramREN, 0);
      chk("t1_idle_iwait", iwait, 0);

      // Simultaneous fetch and write: data first, fetch after one IDLE cycle
      iREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'hDEADBEEF;
      #1;
      serve(1, OC_ACCESS, 32'h0, gd);
      chk("t2_first_is_data", obs_d, 1);
      next_idle();
      dWEN = 0;
      #1;
      serve(1, OC_ACCESS, 32'h12345678, gd);
      chk("t2_second_is_fetch", obs_d, 0);
      next_idle();
      iREN = 0;

      // Starvation guard: both held continuously
      iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h100;
      for (int n = 0; n < 10; n++) begin
         #1;
         serve(1, OC_ACCESS, $urandom, gd);
         chk("t3_grant_order", obs_d, pat[n]);
         next_idle();
      end
      iREN = 0; dREN = 0;

      // Timeout with RAM stuck BUSY
      dREN = 1; daddr = 32'h200;
      #1;
      serve(0, OC_TOUT, 32'h0, gd);
      next_idle();
      dREN = 0;
      #1;
      chk("t4_mem_err_set", mem_err, 1);
      dREN = 1;
      #1;
      serve(1, OC_ACCESS, 32'hCAFEF00D, gd);
      next_idle();
      dREN = 0;
      #1;
      chk("t4_mem_err_sticky", mem_err, 1);

      // RAM ERROR on fetch, then read+write together
      iREN = 1; iaddr = 32'h44;
      #1;
      serve(3, OC_ERROR, 32'h0, gd);
      next_idle();
      iREN = 0; dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h5A5A5A5A;
      #1;
      serve(1, OC_ACCESS, 32'h0, gd);
      next_idle();
      dREN = 0; dWEN = 0;

      // Asynchronous reset in the middle of a write grant
      dWEN = 1; daddr = 32'h400; dstore = 32'h11112222;
      #1;
      chk("t6_err_before_rst", mem_err, 1);
      tick();
      ramstate = RS_BUSY;
      #1;
      chk("t6_wen_in_grant", ramWEN, 1);
      #1;
      nRST = 1'b0;
      #1;
      chk("t6_wen_async_drop", ramWEN, 0);
      chk("t6_err_cleared", mem_err, 0);
      m_err = 0; m_streak = 0;
      dWEN = 0; ramstate = RS_FREE;
      #2;
      nRST = 1'b1;
      next_idle();

      // Abort keeps the streak: three data completions, abort, then one more data before fetch
      iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h500;
      for (int n = 0; n < 3; n++) begin
         #1;
         serve(1, OC_ACCESS, $urandom, gd);
         next_idle();
      end
      #1;
      tick();
      ramstate = RS_BUSY;
      #1;
      chk("abort_grant_is_data", ramaddr, 32'h500);
      dREN = 0;
      #1;
      chk("abort_no_dload", dload, 0);
      chk("abort_ramren", ramREN, 0);
      next_idle();
      dREN = 1;
      #1;
      serve(1, OC_ACCESS, 32'h77778888, gd);
      chk("abort_streak_kept_data", obs_d, 1);
      next_idle();
      #1;
      serve(1, OC_ACCESS, 32'h9999AAAA, gd);
      chk("abort_then_fetch", obs_d, 0);
      next_idle();
      iREN = 0; dREN = 0;

      // Randomized traffic; losing requester keeps its request and operands stable
      iREN = 1; iaddr = {1'b0, 31'($urandom)};
      dREN = 1; dWEN = 0; daddr = {1'b1, 31'($urandom)}; dstore = $urandom;
      for (int n = 0; n < 60; n++) begin
         int r, oc;
         r  = $urandom_range(0, 99);
         oc = (r < 85) ? OC_ACCESS : (r < 97) ? OC_ERROR : OC_TOUT;
         #1;
         serve($urandom_range(1, 4), oc, $urandom, gd);
         next_idle();
         if (gd) begin
            r = $urandom_range(0, 3);
            dREN = r[0]; dWEN = r[1];
            daddr = {1'b1, 31'($urandom)}; dstore = $urandom;
         end else begin
            iREN = 1'($urandom_range(0, 1));
            iaddr = {1'b0, 31'($urandom)};
         end
         if (!iREN && !dREN && !dWEN) iREN = 1;
      end
      iREN = 0; dREN = 0; dWEN = 0;
      #1;
      chk("final_mem_err", mem_err, m_err);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
